icache_fetch: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipeline fetch port and the backing instruction memory.
- Pipeline side: takes pc_F, returns inst_F and inst_mem_ack_F. The pipeline stalls fetch while inst_mem_ack_F is low.
- On a miss it refills one whole line from backing memory using a single-outstanding req/ack handshake, then serves the hit.

---
 rtl/icache_fetch.sv | 153 +++++++++++++++
 tb/tb_icache_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache between the fetch stage and backing memory.
// Latency: a hit is answered combinationally in the same cycle. A miss refills a whole line,
//          always starting at word 0, then answers 1 + (sum of per-word memory cycles) + 1 cycles later.
// Backpressure: inst_mem_ack_F stays low while a refill runs. Backing memory stalls the refill by
//               holding mem_ack low, and mem_req/mem_addr stay stable until mem_ack arrives.
// Ports:
//   clk, reset        - clock; asynchronous active-low reset
//   pc_F              - fetch address (bits [1:0] ignored)
//   inst_F            - instruction, valid when inst_mem_ack_F is high, otherwise 0
//   inst_mem_ack_F    - inst_F is valid for the current pc_F this cycle
//   inval             - pulse that invalidates every line
//   mem_req, mem_addr - single-outstanding word read request to backing memory
//   mem_rdata, mem_ack- read data and its completion strobe
module icache_fetch #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_F,
   output logic [31:0] inst_F,
   output logic        inst_mem_ack_F,
   input  logic        inval,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TW = 30 - OB - IB;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     miss_tag_q, miss_tag_d;
   logic [IB-1:0]     miss_index_q, miss_index_d;
   logic [OB-1:0]     cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic [LINES-1:0]  valid_q, valid_d;

   // Storage arrays are not reset; the valid bits alone decide what is usable.
   logic [31:0]       data_q [LINES][WORDS];
   logic [TW-1:0]     tag_q  [LINES];

   logic [OB-1:0]     pc_word;
   logic [IB-1:0]     pc_index;
   logic [TW-1:0]     pc_tag;
   logic              lookup_hit;
   logic              unused_pc_bits;

   assign pc_word        = pc_F[OB+1:2];
   assign pc_index       = pc_F[OB+IB+1:OB+2];
   assign pc_tag         = pc_F[31:OB+IB+2];
   assign unused_pc_bits = ^pc_F[1:0];

   assign lookup_hit = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

   // An invalidation in IDLE suppresses the answer for that cycle even though the
   // lookup still matches. The FSM stays in IDLE, and the next cycle misses because
   // the valid bits have been cleared.
   always_comb begin
      inst_mem_ack_F = (state_q == IDLE) && lookup_hit && !inval;
      inst_F         = '0;
      if (inst_mem_ack_F) begin
         inst_F = data_q[pc_index][pc_word];
      end
   end

   always_comb begin
      state_d      = state_q;
      miss_tag_d   = miss_tag_q;
      miss_index_d = miss_index_q;
      cnt_d        = cnt_q;
      mem_req      = 1'b0;
      mem_addr     = '0;
      case (state_q)
         IDLE: begin
            if (!lookup_hit) begin
               miss_tag_d   = pc_tag;
               miss_index_d = pc_index;
               cnt_d        = '0;
               state_d      = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
            if (mem_ack) begin
               cnt_d = cnt_q + OB'(1);
               if (&cnt_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The kill flag remembers an invalidation seen mid-refill, so the refilled line is
   // not published. An invalidation always overrides the DONE valid-bit write.
   always_comb begin
      kill_d  = kill_q;
      valid_d = valid_q;
      if (state_q != IDLE && inval) begin
         kill_d = 1'b1;
      end
      if (state_q == DONE) begin
         kill_d = 1'b0;
         if (!kill_q) begin
            valid_d[miss_index_q] = 1'b1;
         end
      end
      if (inval) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
         cnt_q        <= '0;
         kill_q       <= 1'b0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         miss_tag_q   <= miss_tag_d;
         miss_index_q <= miss_index_d;
         cnt_q        <= cnt_d;
         kill_q       <= kill_d;
         valid_q      <= valid_d;
      end
   end

   // While reset is held the FSM sits in IDLE, so neither write can fire.
   always_ff @(posedge clk) begin
      if (state_q == FILL && mem_ack) begin
         data_q[miss_index_q][cnt_q] <= mem_rdata;
      end
      if (state_q == DONE) begin
         tag_q[miss_index_q] <= miss_tag_q;
      end
   end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios followed by randomized fetches against a
// transaction-level model. The model tracks which line holds which tag and the expected
// fetch latency, and the bench acts as backing memory with programmable wait states.
module tb_icache_fetch;

   localparam logic [31:0] KEY = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_F;
   logic [31:0] inst_F;
   logic        inst_mem_ack_F;
   logic        inval;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          vectors     = 0;
   int          miscompares = 0;
   int          wait_n      = 0;
   int          wcnt        = 0;
   logic        ack_force   = 1'b0;
   logic [31:0] hs_q[$];
   logic        prev_wait   = 1'b0;
   logic [31:0] prev_addr   = '0;

   icache_fetch #(.LINES(16), .WORDS(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_F           (pc_F),
      .inst_F         (inst_F),
      .inst_mem_ack_F (inst_mem_ack_F),
      .inval          (inval),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
   );

   always #5 clk = ~clk;

   // Memory answers after wait_n idle request cycles. Its contents are a fixed function
   // of the address.
   assign mem_ack   = ack_force | (mem_req && (wcnt >= wait_n));
   assign mem_rdata = mem_addr ^ KEY;

   always @(posedge clk or negedge reset) begin
      if (!reset)                    wcnt <= 0;
      else if (mem_req && !mem_ack)  wcnt <= wcnt + 1;
      else                           wcnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle protocol checks and handshake capture.
   always @(negedge clk) begin
      if (reset) begin
         if (!inst_mem_ack_F) chk("inst_zero", inst_F, 32'h0);
         if (!mem_req)        chk("addr_idle", mem_addr, 32'h0);
         if (prev_wait) begin
            chk("req_hold", {31'h0, mem_req}, 32'h1);
            chk("addr_hold", mem_addr, prev_addr);
         end
         if (mem_req && mem_ack) hs_q.push_back(mem_addr);
         prev_wait = mem_req && !mem_ack;
         prev_addr = mem_addr;
      end else begin
         prev_wait = 1'b0;
      end
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   // Call this right after a rising edge. The current cycle is cycle 0. The task drives
   // pc, then waits for the acknowledge and checks latency, data and the refill addresses.
   task automatic fetch(input logic [31:0] pc, input int exp_lat, input int exp_words,
                        input int inval_at);
      int lat;
      lat = -1;
      hs_q.delete();
      pc_F = pc;
      for (int c = 0; c < 100; c++) begin
         inval = (c == inval_at);
         @(negedge clk);
         if (inst_mem_ack_F) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      inval = 1'b0;
      chk("ack_seen", {31'h0, inst_mem_ack_F}, 32'h1);
      chk("latency", lat, exp_lat);
      chk("data", inst_F, {pc[31:2], 2'b00} ^ KEY);
      chk("n_words", hs_q.size(), exp_words);
      for (int i = 0; i < hs_q.size(); i++) begin
         chk("fill_addr", hs_q[i], {pc[31:4], 4'h0} | 32'((i % 4) * 4));
      end
   endtask

   bit          mvalid [16];
   int          mtag   [16];

   initial begin
      logic [31:0] pc;
      int          tg, ix, wd, wn, lat, nw;
      bit          iv, hit;

      reset = 1'b0;
      pc_F  = 32'h0;
      inval = 1'b0;
      #2;
      chk("rst_req",  {31'h0, mem_req}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_ack",  {31'h0, inst_mem_ack_F}, 32'h0);
      chk("rst_inst", inst_F, 32'h0);
      repeat (2) @(posedge clk);

      // Cold miss with a zero-wait memory, then a hit on the filled line.
      next_cyc; reset = 1'b1;
      fetch(32'h40, 6, 4, -1);
      chk("cold_inst", inst_F, 32'hA5A5A5E5);
      next_cyc; fetch(32'h48, 0, 0, -1);

      // Back-to-back hits across all words, changing pc every cycle.
      for (int w = 0; w < 4; w++) begin
         next_cyc; fetch(32'h40 + 32'(w * 4), 0, 0, -1);
      end

      // Three cycles per word, then a stray mem_ack while no request is pending.
      wait_n = 2;
      next_cyc; fetch(32'h100, 14, 4, -1);
      next_cyc; ack_force = 1'b1;
      fetch(32'h104, 0, 0, -1);
      ack_force = 1'b0;
      next_cyc; fetch(32'h10C, 0, 0, -1);
      wait_n = 0;

      // Same index, different tag: the lines evict each other.
      next_cyc; fetch(32'h440, 6, 4, -1);
      next_cyc; fetch(32'h40, 6, 4, -1);

      // Asynchronous reset asserted after two refill acks.
      next_cyc; pc_F = 32'h200;
      next_cyc; next_cyc; next_cyc;
      chk("req_pre_rst",  {31'h0, mem_req}, 32'h1);
      chk("addr_pre_rst", mem_addr, 32'h208);
      #1 reset = 1'b0;
      #1;
      chk("req_in_rst",  {31'h0, mem_req}, 32'h0);
      chk("addr_in_rst", mem_addr, 32'h0);
      chk("ack_in_rst",  {31'h0, inst_mem_ack_F}, 32'h0);
      chk("inst_in_rst", inst_F, 32'h0);
      pc_F = 32'h40;
      repeat (2) @(posedge clk);
      next_cyc; reset = 1'b1;
      fetch(32'h40, 6, 4, -1);

      // Invalidate during the second word: the refill completes but is not kept, so the
      // address misses again and triggers a second refill.
      next_cyc; fetch(32'h80, 12, 8, 2);

      // Randomized fetches against the line/tag model.
      next_cyc; reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = 0;
      end
      for (int n = 0; n < 150; n++) begin
         tg  = int'($urandom_range(0, 2));
         ix  = int'($urandom_range(0, 3));
         wd  = int'($urandom_range(0, 3));
         wn  = int'($urandom_range(0, 2));
         iv  = ($urandom_range(0, 7) == 0);
         pc  = 32'((tg << 8) | (ix << 4) | (wd << 2));
         hit = mvalid[ix] && (mtag[ix] == tg);
         lat = 2 + 4 * (wn + 1);
         nw  = 4;
         if (iv) begin
            for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
         end
         if (hit && !iv) begin
            lat = 0;
            nw  = 0;
         end else if (hit && iv) begin
            lat = lat + 1;
         end
         if (!hit || iv) begin
            mvalid[ix] = 1'b1;
            mtag[ix]   = tg;
         end
         wait_n = wn;
         next_cyc; reset = 1'b1;
         fetch(pc, lat, nw, iv ? 0 : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
